// File: rtl/alu_bist_engine_pkg.sv
// Shared definitions for the ALU BIST engine.
// Holds the step polynomial taps, the counter width and the FSM state type.
// Every file of the block imports this package.
package alu_bist_engine_pkg;

  // Step polynomial x^32 + x^22 + x^2 + x + 1. The x^32 term is implied.
  localparam int          STEP_W      = 32;
  localparam logic [31:0] STEP_TAPS   = 32'h00400007;

  // Width of the vector counter. It also sets the upper limit of NUM_VECTORS.
  localparam int          VEC_COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/alu_bist_engine_lfsr_step_32.sv
// One combinational step of the left-shift Galois LFSR/MISR.
// The top instantiates it three times: once for LFSR-A, once for LFSR-B and
// once for the MISR.
//   value   : current register value
//   stepped : value shifted left by one, with the taps applied when the MSB
//             was set
module lfsr_step_32
  import alu_bist_engine_pkg::*;
(
  input  logic [STEP_W-1:0] value,
  output logic [STEP_W-1:0] stepped
);

  assign stepped = {value[STEP_W-2:0], 1'b0} ^ (value[STEP_W-1] ? STEP_TAPS : '0);

endmodule

// File: rtl/alu_bist_engine.sv
// BIST initiator for the ALU operand/result interface.
// On an accepted start it loads two LFSRs with their seeds and drives them on
// A/B, one vector per cycle. Each R is folded into a MISR. At the end the
// signature is compared against GOLDEN_SIG.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   start     : one-cycle run request; ignored while busy
//   A, B      : registered operands to the ALU; they hold their value when idle
//   R         : combinational ALU result for the current A/B
//   busy      : high from the accepted start until FINISH
//   done/pass : run complete / signature matched; held until the next start
//   signature : current MISR value
//   vec_count : vectors absorbed in this run
module alu_bist_engine
  import alu_bist_engine_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NUM_VECTORS = 256,
  parameter logic [WIDTH-1:0] SEED_A      = 32'h0F0F00FF,
  parameter logic [WIDTH-1:0] SEED_B      = 32'hF0FA00FF,
  parameter logic [WIDTH-1:0] GOLDEN_SIG  = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [WIDTH-1:0]       A,
  output logic [WIDTH-1:0]       B,
  input  logic [WIDTH-1:0]       R,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [WIDTH-1:0]       signature,
  output logic [VEC_COUNT_W-1:0] vec_count
);

  // An all-zero seed locks the LFSR at zero, so that case stops the build.
  if (SEED_A == '0 || SEED_B == '0) begin : g_bad_seed
    $error("alu_bist_engine: LFSR seeds must be nonzero");
  end
  if (NUM_VECTORS < 1 || NUM_VECTORS > 65535) begin : g_bad_count
    $error("alu_bist_engine: NUM_VECTORS must be in 1..65535");
  end
  if (WIDTH != STEP_W) begin : g_bad_width
    $error("alu_bist_engine: WIDTH must match the 32-bit step polynomial");
  end

  localparam logic [VEC_COUNT_W-1:0] MAX_VEC  = VEC_COUNT_W'(NUM_VECTORS);
  localparam logic [VEC_COUNT_W-1:0] LAST_VEC = VEC_COUNT_W'(NUM_VECTORS - 1);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, sig_q, sig_d;
  logic [VEC_COUNT_W-1:0] vc_q, vc_d;
  logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [WIDTH-1:0]       a_step, b_step, sig_step;

  lfsr_step_32 u_step_a   (.value(a_q),   .stepped(a_step));
  lfsr_step_32 u_step_b   (.value(b_q),   .stepped(b_step));
  lfsr_step_32 u_step_sig (.value(sig_q), .stepped(sig_step));

  // NOTE: every output of this block gets a default value first. Without
  // the default, an unassigned path through the case would infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sig_d   = sig_q;
    vc_d    = vc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          sig_d   = '0;
          vc_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        a_d     = SEED_A;
        b_d     = SEED_B;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // R belongs to the A/B currently on the bus, so it is absorbed in
        // the same cycle as those operands.
        sig_d = sig_step ^ R;
        if (vc_q != MAX_VEC) begin
          vc_d = vc_q + 1'b1;
        end
        if (vc_q == LAST_VEC) begin
          // A/B keep the last vector so the ALU does not toggle after the run.
          state_d = ST_FINISH;
        end else begin
          a_d = a_step;
          b_d = b_step;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (sig_q == GOLDEN_SIG);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together on the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sig_q   <= '0;
      vc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sig_q   <= sig_d;
      vc_q    <= vc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = vc_q;

endmodule

// File: tb/tb_alu_bist_engine.sv
// Testbench for alu_bist_engine. It uses three instances:
//   u_main : NUM_VECTORS=8, GOLDEN_SIG=0. A random ALU op feeds R, and the
//            outputs are compared every cycle against a behavioural model.
//   u_one  : NUM_VECTORS=1, GOLDEN_SIG=0xFFF50000. Its results are pinned
//            with hand-computed values (XOR, and R forced to zero).
//   u_two  : NUM_VECTORS=2, GOLDEN_SIG=0. Its results are pinned with
//            hand-computed XOR values.
module tb_alu_bist_engine;

  localparam int          NV = 8;
  localparam logic [31:0] SA = 32'h0F0F00FF;
  localparam logic [31:0] SB = 32'hF0FA00FF;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start_m = 1'b0, start_1 = 1'b0, start_2 = 1'b0, zero_1 = 1'b0;
  logic [1:0] op = 2'd0;

  logic [31:0] a_m, b_m, r_m, sig_m, a_1, b_1, r_1, sig_1, a_2, b_2, r_2, sig_2;
  logic        busy_m, done_m, pass_m, busy_1, done_1, pass_1, busy_2, done_2, pass_2;
  logic [15:0] vc_m, vc_1, vc_2;

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s << 1) ^ (s[31] ? 32'h00400007 : 32'h0);
  endfunction

  function automatic logic [31:0] alu(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'd0:    return a ^ b;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a + b;
    endcase
  endfunction

  assign r_m = alu(op, a_m, b_m);
  assign r_1 = zero_1 ? 32'h0 : (a_1 ^ b_1);
  assign r_2 = a_2 ^ b_2;

  alu_bist_engine #(.NUM_VECTORS(NV)) u_main (
    .clk(clk), .rst(rst), .start(start_m), .A(a_m), .B(b_m), .R(r_m),
    .busy(busy_m), .done(done_m), .pass(pass_m), .signature(sig_m), .vec_count(vc_m));

  alu_bist_engine #(.NUM_VECTORS(1), .GOLDEN_SIG(32'hFFF50000)) u_one (
    .clk(clk), .rst(rst), .start(start_1), .A(a_1), .B(b_1), .R(r_1),
    .busy(busy_1), .done(done_1), .pass(pass_1), .signature(sig_1), .vec_count(vc_1));

  alu_bist_engine #(.NUM_VECTORS(2)) u_two (
    .clk(clk), .rst(rst), .start(start_2), .A(a_2), .B(b_2), .R(r_2),
    .busy(busy_2), .done(done_2), .pass(pass_2), .signature(sig_2), .vec_count(vc_2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model of u_main. k counts cycles since the accepted start:
  // k=1 loads the seeds, k=2..NV+1 each absorb one vector, k=NV+2 finishes.
  bit          m_run = 0;
  int          m_k = 0, m_vc = 0;
  logic [31:0] m_a = 0, m_b = 0, m_sig = 0;
  logic        m_busy = 0, m_done = 0, m_pass = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_a = 0; m_b = 0; m_sig = 0; m_vc = 0;
      m_busy = 0; m_done = 0; m_pass = 0;
    end else if (m_run) begin
      m_k++;
      if (m_k == 1) begin
        m_a = SA; m_b = SB;
      end else if (m_k <= NV + 1) begin
        m_sig = step(m_sig) ^ alu(op, m_a, m_b);
        m_vc++;
        if (m_k <= NV) begin
          m_a = step(m_a); m_b = step(m_b);
        end
      end else begin
        m_busy = 0; m_done = 1; m_pass = (m_sig == 32'h0); m_run = 0;
      end
    end else if (start_m) begin
      m_run = 1; m_k = 0; m_sig = 0; m_vc = 0;
      m_done = 0; m_pass = 0; m_busy = 1;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("main_A", a_m, m_a);
      check("main_B", b_m, m_b);
      check("main_sig", sig_m, m_sig);
      check("main_vc", {16'h0, vc_m}, m_vc);
      check("main_busy", {31'h0, busy_m}, {31'h0, m_busy});
      check("main_done", {31'h0, done_m}, {31'h0, m_done});
      if (m_done) check("main_pass", {31'h0, pass_m}, {31'h0, m_pass});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start1();
    start_1 = 1'b1; tick(1); start_1 = 1'b0;
  endtask

  logic [31:0] sig_first;
  logic        pass_first;
  int          first_done, done_rises;
  logic        prev_done;
  int          budget;

  initial begin
    @(posedge clk);
    chk_en = 1;
    tick(1);
    check("rst_one_busy", {31'h0, busy_1}, 32'h0);
    check("rst_one_sig", sig_1, 32'h0);
    check("rst_one_A", a_1, 32'h0);
    check("rst_two_vc", {16'h0, vc_2}, 32'h0);
    rst = 1'b0;
    tick(1);

    // NUM_VECTORS=1, XOR: done arrives at cycle 4.
    pulse_start1();
    check("one_busy_after_start", {31'h0, busy_1}, 32'h1);
    tick(2);
    check("one_done_cycle3", {31'h0, done_1}, 32'h0);
    tick(1);
    check("one_done_cycle4", {31'h0, done_1}, 32'h1);
    check("one_A", a_1, 32'h0F0F00FF);
    check("one_B", b_1, 32'hF0FA00FF);
    check("one_sig", sig_1, 32'hFFF50000);
    check("one_vc", {16'h0, vc_1}, 32'h1);
    check("one_pass", {31'h0, pass_1}, 32'h1);

    // Fault case: R is stuck at zero, so the signature stays zero and pass is low.
    zero_1 = 1'b1;
    pulse_start1();
    check("fault_done_cleared", {31'h0, done_1}, 32'h0);
    tick(3);
    check("fault_done", {31'h0, done_1}, 32'h1);
    check("fault_sig", sig_1, 32'h0);
    check("fault_pass", {31'h0, pass_1}, 32'h0);
    zero_1 = 1'b0;

    // NUM_VECTORS=2, XOR: the second vector cancels the first in the MISR.
    start_2 = 1'b1; tick(1); start_2 = 1'b0;
    budget = 0;
    while (!done_2 && budget < 20) begin tick(1); budget++; end
    check("two_done_in_time", {31'h0, done_2}, 32'h1);
    check("two_A", a_2, 32'h1E1E01FE);
    check("two_B", b_2, 32'hE1B401F9);
    check("two_sig", sig_2, 32'h0);
    check("two_vc", {16'h0, vc_2}, 32'h2);
    check("two_pass", {31'h0, pass_2}, 32'h1);

    // Start pulsed again during RUN: the run must not restart, and done rises once at cycle 11.
    op = 2'd0;
    start_m = 1'b1; tick(1); start_m = 1'b0;
    first_done = -1; done_rises = 0; prev_done = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (done_m && !prev_done) begin
        done_rises++;
        if (first_done < 0) first_done = cyc;
      end
      prev_done = done_m;
      start_m = (cyc == 4);
      tick(1);
    end
    start_m = 1'b0;
    check("restart_done_cycle", first_done, 11);
    check("restart_done_once", done_rises, 1);
    check("restart_vc", {16'h0, vc_m}, NV);
    sig_first  = sig_m;
    pass_first = pass_m;

    // Back-to-back run: the second signature must equal the first.
    start_m = 1'b1; tick(1); start_m = 1'b0;
    check("b2b_done_cleared", {31'h0, done_m}, 32'h0);
    tick(NV + 2);
    check("b2b_done", {31'h0, done_m}, 32'h1);
    check("b2b_sig", sig_m, sig_first);
    check("b2b_pass", {31'h0, pass_m}, {31'h0, pass_first});

    // Reset in RUN cycle 3: the partial signature is discarded, and a later run matches the first.
    start_m = 1'b1; tick(1); start_m = 1'b0;
    tick(3);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("midrst_busy", {31'h0, busy_m}, 32'h0);
    check("midrst_sig", sig_m, 32'h0);
    check("midrst_A", a_m, 32'h0);
    start_m = 1'b1; tick(1); start_m = 1'b0;
    tick(NV + 2);
    check("after_rst_sig", sig_m, sig_first);

    // Start and reset in the same cycle: reset wins.
    rst = 1'b1; start_m = 1'b1; tick(1); rst = 1'b0; start_m = 1'b0;
    check("rst_wins_busy", {31'h0, busy_m}, 32'h0);

    // Randomized runs with a random op, idle gap, stray starts and occasional resets.
    for (int run = 0; run < 24; run++) begin
      budget = 0;
      while (m_run && budget < 40) begin tick(1); budget++; end
      check("rand_idle_before_run", {31'h0, m_run}, 32'h0);
      op = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 3));
      start_m = 1'b1; tick(1); start_m = 1'b0;
      begin
        int rst_at;
        rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, NV + 2)) : -1;
        for (int cyc = 1; cyc <= NV + 3; cyc++) begin
          start_m = (cyc <= NV) && ($urandom_range(0, 3) == 0);
          rst     = (cyc == rst_at);
          tick(1);
        end
        start_m = 1'b0;
        rst     = 1'b0;
      end
      tick(1);
    end

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end within the time limit");
    $fatal(1, "timeout");
  end

endmodule
